// File: rtl/alu_issue_sequencer_pkg.sv
// Shared types and constants for the ALU issue sequencer: instruction fields,
// condition/op encodings, FSM states and register index type.
package alu_issue_sequencer_pkg;

    localparam int COND_LSB = 14;
    localparam int OP_LSB   = 9;
    localparam int RD_LSB   = 6;
    localparam int RN_LSB   = 3;
    localparam int RM_LSB   = 0;

    typedef logic [2:0] reg_idx_t;

    typedef enum logic [1:0] {
        A_TYPE = 2'b00,
        B_TYPE = 2'b01,
        C_TYPE = 2'b10,
        D_TYPE = 2'b11
    } cond_e;

    typedef enum logic [4:0] {
        ADD   = 5'd0,
        EQUAL = 5'd1,
        OR    = 5'd2,
        AND   = 5'd3,
        MINUS = 5'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_WB    = 2'd3
    } state_e;

    function automatic logic [1:0] instr_cond(input logic [15:0] instr);
        return instr[COND_LSB +: 2];
    endfunction

    function automatic logic [4:0] instr_op(input logic [15:0] instr);
        return instr[OP_LSB +: 5];
    endfunction

    function automatic reg_idx_t instr_rd(input logic [15:0] instr);
        return instr[RD_LSB +: 3];
    endfunction

    function automatic reg_idx_t instr_rn(input logic [15:0] instr);
        return instr[RN_LSB +: 3];
    endfunction

    function automatic reg_idx_t instr_rm(input logic [15:0] instr);
        return instr[RM_LSB +: 3];
    endfunction

endpackage

// File: rtl/alu_issue_sequencer_regfile.sv
// 8x16 register file: two operand read ports, one debug read port, one write port.
// Build option R0_ZERO_EN makes r0 a hardwired zero.
module alu_issue_sequencer_regfile
    import alu_issue_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  reg_idx_t    ra_idx,
    input  reg_idx_t    rb_idx,
    input  reg_idx_t    dbg_idx,
    input  logic        we,
    input  reg_idx_t    waddr,
    input  logic [15:0] wdata,
    output logic [15:0] ra_data,
    output logic [15:0] rb_data,
    output logic [15:0] dbg_data
);

`ifdef R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];

    always_comb begin
        regs_d = regs_q;
        if (we && !(R0_ZERO && (waddr == 3'd0))) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads see the registered value, so a same-cycle write shows up one cycle later.
    assign ra_data  = (R0_ZERO && (ra_idx  == 3'd0)) ? 16'h0000 : regs_q[ra_idx];
    assign rb_data  = (R0_ZERO && (rb_idx  == 3'd0)) ? 16'h0000 : regs_q[rb_idx];
    assign dbg_data = (R0_ZERO && (dbg_idx == 3'd0)) ? 16'h0000 : regs_q[dbg_idx];

endmodule

// File: rtl/alu_issue_sequencer.sv
// Fetch/exec/writeback sequencer feeding an external combinational ALU.
// Optional build macro R0_ZERO_EN (handled in the register file) pins r0 to zero.
module alu_issue_sequencer
    import alu_issue_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [15:0]       imem_data,
    output logic [15:0]       alu_rn,
    output logic [15:0]       alu_rm,
    output logic [15:0]       alu_instr,
    input  logic [15:0]       alu_rd,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    input  logic              dbg_we,
    input  logic [2:0]        dbg_waddr,
    input  logic [15:0]       dbg_wdata,
    input  logic [2:0]        dbg_raddr,
    output logic [15:0]       dbg_rdata
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic [15:0]       result_q, result_d;

    logic              rf_we;
    reg_idx_t          rf_waddr;
    logic [15:0]       rf_wdata;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        result_d = result_q;
        imem_req = 1'b0;
        retire   = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = dbg_waddr;
        rf_wdata = dbg_wdata;
        unique case (state_q)
            S_IDLE: begin
                rf_we = dbg_we;
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    instr_d = imem_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = alu_rd;
                state_d  = S_WB;
            end
            S_WB: begin
                retire = 1'b1;
                pc_d   = pc_q + ADDR_W'(1);
                // Non-A_TYPE instructions retire as NOPs.
                if (instr_cond(instr_q) == A_TYPE) begin
                    rf_we    = 1'b1;
                    rf_waddr = instr_rd(instr_q);
                    rf_wdata = result_q;
                end
                state_d = run ? S_FETCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= PC_RESET;
            instr_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            result_q <= result_d;
        end
    end

    alu_issue_sequencer_regfile u_regfile (
        .clk      (clk),
        .reset    (reset),
        .ra_idx   (instr_rn(instr_q)),
        .rb_idx   (instr_rm(instr_q)),
        .dbg_idx  (dbg_raddr),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .ra_data  (alu_rn),
        .rb_data  (alu_rm),
        .dbg_data (dbg_rdata)
    );

    assign alu_instr = instr_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Randomized scoreboard bench for alu_issue_sequencer; plays instruction memory and ALU.
module tb_alu_issue_sequencer;
    import alu_issue_sequencer_pkg::*;

    localparam int          ADDR_W = 16;
    localparam logic [15:0] PC_RST = 16'hFFFE;
`ifdef R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic        clk, reset, run;
    logic        imem_req, imem_valid, retire, dbg_we;
    logic [15:0] imem_addr, imem_data, alu_rn, alu_rm, alu_instr, alu_rd, pc;
    logic [2:0]  dbg_waddr, dbg_raddr, stim_raddr, mon_raddr;
    logic [15:0] dbg_wdata, dbg_rdata;
    logic        sel_mon;

    typedef struct {
        logic [15:0] pc;
        logic [2:0]  rd;
        logic [15:0] oldv;
        logic [15:0] newv;
    } exp_t;

    exp_t        exp_q[$];
    int          rd_idx = 0;
    bit          mon_pending = 0;
    logic [15:0] ref_regs [8];
    logic [15:0] ref_pc;
    int          checks = 0;
    int          failures = 0;

    assign dbg_raddr = sel_mon ? mon_raddr : stim_raddr;

    alu_issue_sequencer #(.ADDR_W(ADDR_W), .PC_RESET(PC_RST)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
        .alu_rn(alu_rn), .alu_rm(alu_rm), .alu_instr(alu_instr), .alu_rd(alu_rd),
        .pc(pc), .retire(retire),
        .dbg_we(dbg_we), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behaviour of the external ALU, shared by the environment and the reference model.
    function automatic logic [15:0] alu_model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            ADD:     return a + b;
            EQUAL:   return {15'd0, a == b};
            OR:      return a | b;
            AND:     return a & b;
            MINUS:   return a - b;
            default: return 16'h0000;
        endcase
    endfunction

    assign alu_rd = alu_model(alu_instr[13:9], alu_rn, alu_rm);

    function automatic logic [15:0] ref_rd(input logic [2:0] idx);
        return (R0Z && idx == 3'd0) ? 16'h0000 : ref_regs[idx];
    endfunction

    function automatic logic [15:0] mk(input logic [1:0] c, input logic [4:0] op,
                                       input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm);
        return {c, op, rd, rn, rm};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        exp_t pe;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_pending = 0;
                rd_idx = exp_q.size();
            end else if (retire) begin
                if (rd_idx >= exp_q.size()) begin
                    chk("unexpected_retire", 16'(retire), 16'd0);
                end else begin
                    e = exp_q[rd_idx];
                    rd_idx++;
                    chk("retire_pc", pc, e.pc);
                    chk("wb_cycle_rdata_old", dbg_rdata, e.oldv);
                    pe = e;
                    mon_pending = 1;
                end
            end else if (mon_pending) begin
                chk("after_wb_rdata_new", dbg_rdata, pe.newv);
                chk("after_wb_pc", pc, pe.pc + 16'd1);
                mon_pending = 0;
            end
            if (mon_pending) mon_raddr = pe.rd;
            else if (rd_idx < exp_q.size()) mon_raddr = exp_q[rd_idx].rd;
        end
    endtask

    task automatic reset_checks();
        sel_mon = 1'b0;
        chk("rst_pc", pc, PC_RST);
        chk("rst_imem_req", 16'(imem_req), 16'd0);
        chk("rst_retire", 16'(retire), 16'd0);
        chk("rst_instr", alu_instr, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            stim_raddr = 3'(i);
            #1;
            chk("rst_reg", dbg_rdata, 16'h0000);
        end
        sel_mon = 1'b1;
    endtask

    task automatic dbg_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        dbg_we = 1'b1; dbg_waddr = a; dbg_wdata = d;
        @(posedge clk);
        #1 dbg_we = 1'b0;
        if (!(R0Z && a == 3'd0)) ref_regs[a] = d;
    endtask

    task automatic dbg_check(input logic [2:0] a);
        @(negedge clk);
        sel_mon = 1'b0; stim_raddr = a;
        #1 chk("dbg_read", dbg_rdata, ref_rd(a));
        sel_mon = 1'b1;
    endtask

    // Serve one fetch after wait_n stall cycles; returns at the negedge of the exec cycle.
    task automatic run_instr(input logic [15:0] instr, input int wait_n, input bit drop_run, input bit abort);
        int n;
        exp_t e;
        logic [15:0] res;
        n = 0;
        @(negedge clk);
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            chk("fetch_req_timeout", 16'(imem_req), 16'd1);
            return;
        end
        for (int i = 0; i < wait_n; i++) begin
            chk("fetch_hold_addr", imem_addr, ref_pc);
            chk("fetch_hold_req_ret", {14'd0, imem_req, retire}, 16'b10);
            imem_valid = 1'b0;
            dbg_we = 1'b1; dbg_waddr = 3'($urandom); dbg_wdata = 16'($urandom);
            @(negedge clk);
        end
        chk("fetch_addr", imem_addr, ref_pc);
        dbg_we = 1'b0; imem_valid = 1'b1; imem_data = instr;
        @(posedge clk);
        if (!abort) begin
            res    = alu_model(instr[13:9], ref_rd(instr[5:3]), ref_rd(instr[2:0]));
            e.pc   = ref_pc;
            e.rd   = instr[8:6];
            e.oldv = ref_rd(instr[8:6]);
            if (instr[15:14] == A_TYPE && !(R0Z && instr[8:6] == 3'd0)) ref_regs[instr[8:6]] = res;
            e.newv = ref_rd(instr[8:6]);
            exp_q.push_back(e);
            ref_pc = ref_pc + 16'd1;
        end
        #1;
        imem_valid = 1'($urandom); imem_data = 16'($urandom);
        dbg_we = 1'($urandom); dbg_waddr = 3'($urandom); dbg_wdata = 16'($urandom);
        if (abort) reset = 1'b1;
        @(negedge clk);
        dbg_we = 1'b0;
        if (drop_run) run = 1'b0;
    endtask

    task automatic stop_checks();
        @(negedge clk);
        @(negedge clk);
        chk("stop_imem_req", 16'(imem_req), 16'd0);
        chk("stop_pc", pc, ref_pc);
        @(negedge clk);
        chk("idle_imem_req", 16'(imem_req), 16'd0);
        chk("idle_retire", 16'(retire), 16'd0);
    endtask

    task automatic random_burst(input int cnt);
        logic [1:0] c;
        @(negedge clk);
        run = 1'b1;
        for (int i = 0; i < cnt; i++) begin
            c = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : A_TYPE;
            run_instr(mk(c, 5'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom)),
                      $urandom_range(0, 3), i == cnt - 1, 1'b0);
        end
        stop_checks();
    endtask

    initial begin
        int n;
        reset = 1'b1; run = 1'b0; imem_valid = 1'b0; imem_data = '0;
        dbg_we = 1'b0; dbg_waddr = '0; dbg_wdata = '0;
        stim_raddr = '0; mon_raddr = '0; sel_mon = 1'b1;
        for (int i = 0; i < 8; i++) ref_regs[i] = 16'h0000;
        ref_pc = PC_RST;
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        reset_checks();

        dbg_write(3'd1, 16'h0003);
        dbg_write(3'd2, 16'h0005);
        dbg_check(3'd1);
        dbg_check(3'd2);

        @(negedge clk);
        run = 1'b1;
        run_instr(mk(A_TYPE, ADD,   3'd3, 3'd1, 3'd2), 0, 0, 0);
        run_instr(mk(A_TYPE, MINUS, 3'd4, 3'd1, 3'd2), 0, 0, 0);
        run_instr(mk(A_TYPE, OR,    3'd5, 3'd1, 3'd2), 0, 0, 0);
        run_instr(mk(B_TYPE, ADD,   3'd1, 3'd1, 3'd2), 0, 0, 0);
        run_instr(mk(A_TYPE, ADD,   3'd0, 3'd1, 3'd2), 5, 0, 0);
        run_instr(mk(A_TYPE, EQUAL, 3'd6, 3'd1, 3'd1), 1, 0, 0);
        run_instr(mk(A_TYPE, ADD,   3'd1, 3'd1, 3'd1), 0, 1, 0);
        stop_checks();
        for (int i = 0; i < 8; i++) dbg_check(3'(i));

        random_burst(24);
        for (int i = 0; i < 8; i++) dbg_check(3'(i));

        // Reset while an instruction is in exec: no writeback, no retire.
        @(negedge clk);
        run = 1'b1;
        run_instr(mk(A_TYPE, ADD, 3'd7, 3'd1, 3'd2), 0, 0, 1);
        run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) ref_regs[i] = 16'h0000;
        ref_pc = PC_RST;
        reset_checks();

        dbg_write(3'd0, 16'h1234);
        dbg_write(3'd1, 16'(16'hFFFF));
        dbg_write(3'(3'd2), 16'($urandom));
        dbg_check(3'd0);
        random_burst(12);
        for (int i = 0; i < 8; i++) dbg_check(3'(i));

        n = 0;
        while ((rd_idx < exp_q.size() || mon_pending) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (rd_idx < exp_q.size()) chk("retire_count", 16'(rd_idx), 16'(exp_q.size()));
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
